pmod_jstk_spi: RTL

SPI master for the PmodJSTK joystick, fed by the 66.67 kHz divided clock from the upstream clock divider. The block runs on `clk` (100 MHz) and treats every edge of the divided clock as a timing tick. On `start` it runs one 5-byte mode-0 SPI transaction: it sends the LED command and receives the X/Y position and button state. It then publishes the decoded values atomically to the game logic.

---
 rtl/jstk_pkg.sv | 16 +
 rtl/jstk_tick_gen.sv | 23 ++
 rtl/pmod_jstk_spi.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/jstk_pkg.sv
// Shared definitions for the PmodJSTK SPI master: FSM encoding and
// command/transaction constants.
package jstk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_FINISH
    } jstk_state_t;

    localparam logic [5:0] JSTK_CMD_PREFIX = 6'b100000;
    localparam int         JSTK_NBYTES     = 5;

endpackage

// File: rtl/jstk_tick_gen.sv
// Brings the divided SPI timing clock into the clk domain and emits a
// one-cycle tick on each of its edges.
module jstk_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic clk_src,
    output logic tick
);

    // sync[1:0] is the 2-FF synchroniser, sync[2] holds the previous level
    logic [2:0] sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            tick <= 1'b0;
        end else begin
            sync <= {sync[1:0], clk_src};
            tick <= sync[2] ^ sync[1];
        end
    end

endmodule

// File: rtl/pmod_jstk_spi.sv
// SPI mode-0 master for the PmodJSTK: sends the LED command, reads five
// bytes and publishes X/Y/buttons together with a done pulse.
module pmod_jstk_spi
    import jstk_pkg::*;
#(
    parameter int SETUP_TICKS = 3,
    parameter int GAP_TICKS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_src,
    input  logic       start,
    input  logic [1:0] leds,
    input  logic       miso,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    output logic       busy,
    output logic       done,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [2:0] btn
);

    jstk_state_t state, state_next;
    logic        tick;
    logic [7:0]  tick_cnt;
    logic [3:0]  bit_cnt;
    logic [2:0]  byte_idx;
    logic [7:0]  tx;
    logic [7:0]  rx_sh;
    logic [7:0]  rx [JSTK_NBYTES];
    logic        ss_d, sclk_d, busy_d, done_d;
    logic        setup_last, gap_last, last_byte;

    jstk_tick_gen u_tick (
        .clk     (clk),
        .rst     (rst),
        .clk_src (clk_src),
        .tick    (tick)
    );

    assign setup_last = (tick_cnt == 8'(SETUP_TICKS - 1));
    assign gap_last   = (tick_cnt == 8'(GAP_TICKS - 1));
    assign last_byte  = (byte_idx == 3'(JSTK_NBYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_SETUP;
            ST_SETUP:  if (tick && setup_last) state_next = ST_SHIFT;
            ST_SHIFT:  if (tick && bit_cnt == 4'd15)
                           state_next = last_byte ? ST_FINISH : ST_GAP;
            ST_GAP:    if (tick && gap_last) state_next = ST_SHIFT;
            ST_FINISH: if (tick) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Next values of the control outputs; registered below with the datapath
    always_comb begin
        ss_d   = ss;
        sclk_d = sclk;
        busy_d = busy;
        done_d = 1'b0;
        if (state == ST_IDLE && start) begin
            ss_d   = 1'b0;
            busy_d = 1'b1;
        end
        if (state == ST_SHIFT && tick)
            sclk_d = ~bit_cnt[0];
        if (state == ST_FINISH && tick) begin
            ss_d   = 1'b1;
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss       <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            x        <= '0;
            y        <= '0;
            btn      <= '0;
            tx       <= '0;
            rx_sh    <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            for (int i = 0; i < JSTK_NBYTES; i++) rx[i] <= '0;
        end else begin
            ss   <= ss_d;
            sclk <= sclk_d;
            busy <= busy_d;
            done <= done_d;
            case (state)
                ST_IDLE: if (start) begin
                    tx       <= {JSTK_CMD_PREFIX, leds};
                    mosi     <= JSTK_CMD_PREFIX[5];
                    byte_idx <= '0;
                    tick_cnt <= '0;
                end
                ST_SETUP: if (tick) begin
                    tick_cnt <= tick_cnt + 8'd1;
                    bit_cnt  <= '0;
                end
                ST_SHIFT: if (tick) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    // Rising half samples, falling half presents the next bit
                    if (!bit_cnt[0]) begin
                        rx_sh <= {rx_sh[6:0], miso};
                    end else if (bit_cnt != 4'd15) begin
                        tx   <= {tx[6:0], 1'b0};
                        mosi <= tx[6];
                    end
                    if (bit_cnt == 4'd15) begin
                        rx[byte_idx] <= rx_sh;
                        tick_cnt     <= '0;
                    end
                end
                ST_GAP: if (tick) begin
                    tick_cnt <= tick_cnt + 8'd1;
                    if (gap_last) begin
                        byte_idx <= byte_idx + 3'd1;
                        tx       <= '0;
                        mosi     <= 1'b0;
                        bit_cnt  <= '0;
                    end
                end
                ST_FINISH: if (tick) begin
                    x   <= {rx[1][1:0], rx[0]};
                    y   <= {rx[3][1:0], rx[2]};
                    btn <= rx[4][2:0];
                end
                default: ;
            endcase
        end
    end

endmodule
